// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: opcodes, controller states and bus widths shared by the memory access controller.
package mips_cpu_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} ctrl_state_t;
endpackage

// File: rtl/mips_cpu_lane_ctrl.sv
// mips_cpu_lane_ctrl: decodes a load/store opcode into byte lanes, store data placement and load extension.
module mips_cpu_lane_ctrl import mips_cpu_pkg::*; (
  input  logic [5:0]        op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] readdata,
  output logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              illegal,
  output logic              is_store
);
  logic sz_b, sz_h;
  logic [DATA_W-1:0] shifted;
  always_comb begin
    sz_b       = op inside {OP_LB, OP_LBU, OP_SB};
    sz_h       = op inside {OP_LH, OP_LHU, OP_SH};
    illegal    = !(op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW});
    is_store   = op inside {OP_SB, OP_SH, OP_SW};
    misalign   = (sz_h & addr_lo[0]) | (!sz_b & !sz_h & !illegal & (|addr_lo));
    byteenable = sz_b ? 4'b0001 << addr_lo : sz_h ? 4'b0011 << addr_lo : 4'b1111;
    writedata  = sz_b ? {4{wdata[7:0]}} : sz_h ? {2{wdata[15:0]}} : wdata;
    // bring the addressed lane down to bit 0 before extending
    shifted    = readdata >> {addr_lo, 3'b000};
    rdata      = op == OP_LB  ? {{24{shifted[7]}}, shifted[7:0]} :
                 op == OP_LBU ? {24'b0, shifted[7:0]} :
                 op == OP_LH  ? {{16{shifted[15]}}, shifted[15:0]} :
                 op == OP_LHU ? {16'b0, shifted[15:0]} : readdata;
  end
endmodule

// File: rtl/mips_cpu_mem_access_ctrl.sv
// mips_cpu_mem_access_ctrl: runs one CPU load/store at a time on the Avalon-MM data port
// with waitrequest stall handling, a stall timeout and a single response pulse per request.
module mips_cpu_mem_access_ctrl import mips_cpu_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [DATA_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [BE_W-1:0]   avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata
);
  ctrl_state_t state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic idle, access;
  logic [BE_W-1:0] lane_be;
  logic [DATA_W-1:0] lane_wd, lane_rd;
  logic misalign, illegal, is_store;
  assign idle   = state_q == IDLE;
  assign access = state_q == ACCESS;
  // decode the live request while idle, the captured one afterwards
  mips_cpu_lane_ctrl u_lane (
    .op         (idle ? req_op : op_q),
    .addr_lo    (idle ? req_addr[1:0] : addr_q[1:0]),
    .wdata      (wdata_q),
    .readdata   (avm_readdata),
    .byteenable (lane_be),
    .writedata  (lane_wd),
    .rdata      (lane_rd),
    .misalign   (misalign),
    .illegal    (illegal),
    .is_store   (is_store)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        op_d    = req_op;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        err_d   = illegal | misalign;
        state_d = (illegal | misalign) ? RESP : ACCESS;
      end
      ACCESS: if (!avm_waitrequest) begin
        rdata_d = is_store ? '0 : lane_rd;
        err_d   = 1'b0;
        state_d = RESP;
      end else if (cnt_q == 16'(TIMEOUT_CYCLES)) begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  assign req_ready      = idle;
  assign resp_valid     = state_q == RESP;
  assign resp_rdata     = resp_valid ? rdata_q : '0;
  assign resp_err       = resp_valid & err_q;
  assign avm_address    = access ? {addr_q[31:2], 2'b00} : '0;
  assign avm_read       = access & !is_store;
  assign avm_write      = access & is_store;
  assign avm_writedata  = access ? lane_wd : '0;
  assign avm_byteenable = access ? lane_be : '0;
endmodule

// File: tb/tb_mips_cpu_mem_access_ctrl.sv
// tb_mips_cpu_mem_access_ctrl: scenario tasks drive requests and check the bus inline;
// a response scoreboard compares every resp_valid pulse against queued expectations.
module tb_mips_cpu_mem_access_ctrl;
  localparam int T = 4;
  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100,
                         LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
  typedef struct {logic [31:0] rdata; logic err; string name;} resp_t;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready;
  logic [5:0] req_op = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_err;
  logic [31:0] resp_rdata, avm_address, avm_writedata, avm_readdata = 0;
  logic avm_read, avm_write, avm_waitrequest = 0;
  logic [3:0] avm_byteenable;
  int n_cmp = 0, n_bad = 0;
  resp_t sb_q[$];
  mips_cpu_mem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (avm_read && avm_write) begin
      n_cmp++; n_bad++;
      $display("FAIL strobe_excl: read and write both high");
    end
    if (resp_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: rdata=%h err=%b, required no response", resp_rdata, resp_err);
      end else begin
        resp_t e;
        e = sb_q.pop_front();
        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
          n_bad++;
          $display("FAIL resp_%s: rdata=%h err=%b, required rdata=%h err=%b", e.name, resp_rdata, resp_err, e.rdata, e.err);
        end
      end
    end
  end
  task automatic run_req(input logic [5:0] op, input logic [31:0] addr, wdata, rd, input int nwait,
                         input int exp_strobes, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         exp_rdata, input logic exp_err, input logic bus, input string name);
    logic store;
    int strobes;
    store = op[3];
    strobes = 0;
    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata;
    avm_readdata = rd; avm_waitrequest = 0;
    sb_q.push_back('{exp_rdata, exp_err, name});
    @(negedge clk);
    req_valid = 0; req_op = 6'b111111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hDEAD_BEEF;
    if (!bus) begin
      n_cmp++;
      if (resp_valid !== 1 || avm_read !== 0 || avm_write !== 0) begin
        n_bad++;
        $display("FAIL early_%s: resp_valid=%b read=%b write=%b, required 1 0 0", name, resp_valid, avm_read, avm_write);
      end
    end else begin
      for (int k = 0; k < 64; k++) begin
        if (!(avm_read || avm_write)) break;
        strobes++;
        n_cmp++;
        if (avm_address !== {addr[31:2], 2'b00} || avm_byteenable !== exp_be || avm_read !== !store ||
            avm_write !== store || req_ready !== 0 || (store && avm_writedata !== exp_wd)) begin
          n_bad++;
          $display("FAIL bus_%s: addr=%h be=%b wd=%h rd=%b wr=%b rdy=%b, required addr=%h be=%b wd=%h rd=%b wr=%b rdy=0",
                   name, avm_address, avm_byteenable, avm_writedata, avm_read, avm_write, req_ready,
                   {addr[31:2], 2'b00}, exp_be, exp_wd, !store, store);
        end
        avm_waitrequest = (k < nwait);
        @(negedge clk);
      end
      n_cmp++;
      if (strobes !== exp_strobes || resp_valid !== 1) begin
        n_bad++;
        $display("FAIL timing_%s: strobe cycles=%0d resp_valid=%b, required %0d and 1", name, strobes, resp_valid, exp_strobes);
      end
    end
    avm_waitrequest = 0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1 || resp_valid !== 0) begin
      n_bad++;
      $display("FAIL ready_%s: req_ready=%b resp_valid=%b, required 1 0", name, req_ready, resp_valid);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1 || resp_valid !== 0 || resp_rdata !== 0 || resp_err !== 0 || avm_read !== 0 ||
        avm_write !== 0 || avm_address !== 0 || avm_writedata !== 0 || avm_byteenable !== 0) begin
      n_bad++;
      $display("FAIL reset_values: ready=%b rv=%b rd=%b wr=%b addr=%h be=%b, required 1 0 0 0 0 0",
               req_ready, resp_valid, avm_read, avm_write, avm_address, avm_byteenable);
    end
    rst_n = 1;
  endtask
  task automatic test_stores();
    run_req(SB, 32'h1003, 32'h0000_00A5, 0, 0, 1, 4'b1000, 32'hA5A5_A5A5, 0, 0, 1, "sb");
    run_req(SH, 32'h6002, 32'h1234_ABCD, 0, 1, 2, 4'b1100, 32'hABCD_ABCD, 0, 0, 1, "sh");
    run_req(SW, 32'h6004, 32'h0BAD_F00D, 0, 2, 3, 4'b1111, 32'h0BAD_F00D, 0, 0, 1, "sw");
  endtask
  task automatic test_loads();
    run_req(LB,  32'h2001, 0, 32'h1234_8056, 3, 4, 4'b0010, 0, 32'hFFFF_FF80, 0, 1, "lb");
    run_req(LBU, 32'h2001, 0, 32'h1234_8056, 3, 4, 4'b0010, 0, 32'h0000_0080, 0, 1, "lbu");
    run_req(LH,  32'h3002, 0, 32'hBEEF_1234, 0, 1, 4'b1100, 0, 32'hFFFF_BEEF, 0, 1, "lh");
    run_req(LHU, 32'h3002, 0, 32'hBEEF_1234, 0, 1, 4'b1100, 0, 32'h0000_BEEF, 0, 1, "lhu");
    run_req(LW,  32'h3008, 0, 32'h8765_4321, 1, 2, 4'b1111, 0, 32'h8765_4321, 0, 1, "lw");
  endtask
  task automatic test_errors();
    run_req(SW, 32'h4002, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 1, 0, "sw_misalign");
    run_req(6'b001000, 32'h4000, 0, 0, 0, 0, 0, 0, 0, 1, 0, "illegal_op");
    run_req(LH, 32'h3001, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 1, 0, "lh_misalign");
  endtask
  task automatic test_timeout();
    run_req(LW, 32'h8000, 0, 32'h5555_AAAA, 1000, T + 1, 4'b1111, 0, 0, 1, 1, "lw_timeout");
    run_req(LW, 32'h8004, 0, 32'hCAFE_F00D, T, T + 1, 4'b1111, 0, 32'hCAFE_F00D, 0, 1, "lw_edge");
  endtask
  task automatic test_random_loads();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, rd, sh, exp;
      logic [5:0] op;
      int nw;
      a  = 32'h7000 + 32'($urandom_range(0, 3));
      rd = $urandom;
      op = (i % 2) ? LB : LBU;
      nw = $urandom_range(0, 2);
      sh = rd >> (8 * a[1:0]);
      exp = (op == LB) ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      run_req(op, a, 0, rd, nw, nw + 1, 4'b0001 << a[1:0], 0, exp, 0, 1, "rand_byte");
    end
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1; req_op = SW; req_addr = 32'h5000; req_wdata = 32'h0000_0001; avm_waitrequest = 1;
    @(negedge clk);
    req_valid = 0;
    n_cmp++;
    if (avm_write !== 1) begin
      n_bad++;
      $display("FAIL mid_pre: write=%b, required 1", avm_write);
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (avm_write !== 0 || avm_read !== 0) begin
      n_bad++;
      $display("FAIL mid_async: write=%b read=%b, required 0 0", avm_write, avm_read);
    end
    repeat (3) @(negedge clk);
    rst_n = 1; avm_waitrequest = 0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1) begin
      n_bad++;
      $display("FAIL mid_ready: req_ready=%b, required 1", req_ready);
    end
    run_req(SW, 32'h5004, 32'h1357_9BDF, 0, 0, 1, 4'b1111, 32'h1357_9BDF, 0, 0, 1, "sw_after_rst");
  endtask
  task automatic test_back_to_back();
    run_req(SB, 32'h9000, 32'h0000_0011, 0, 0, 1, 4'b0001, 32'h1111_1111, 0, 0, 1, "b2b_0");
    run_req(LHU, 32'h9000, 0, 32'h0102_F3F4, 0, 1, 4'b0011, 0, 32'h0000_F3F4, 0, 1, "b2b_1");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_errors();
    test_timeout();
    test_random_loads();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_resp: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
